// File: rtl/x_top_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// x_top_mem_arb_pkg
// Shared types and constants for the two-requester memory arbiter:
//   - arb_state_t : sequencer states (IDLE, REQ, RESP)
//   - N_REQ       : number of requesters
//   - req_idx_t   : requester index type
//   - ERR_DATA_DEFAULT : read data returned when a transaction times out
// ---------------------------------------------------------------------------
package x_top_mem_arb_pkg;

    localparam int N_REQ = 2;

    typedef logic [$clog2(N_REQ)-1:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/x_top_mem_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// x_top_rr_pick
// Combinational 2-way round-robin selector.
//   i_valid     : request vector, bit n = requester n
//   i_ptr       : requester currently holding priority
//   o_grant     : selected requester index
//   o_gnt_valid : at least one requester is asking
// The priority holder wins whenever it requests; otherwise the other one is
// chosen. o_grant is meaningless while o_gnt_valid is low.
// ---------------------------------------------------------------------------
module x_top_rr_pick
    import x_top_mem_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_valid,
    input  req_idx_t         i_ptr,
    output req_idx_t         o_grant,
    output logic             o_gnt_valid
);

    always_comb begin
        o_grant     = i_ptr;
        if (!i_valid[i_ptr]) begin
            o_grant = ~i_ptr;
        end
        o_gnt_valid = |i_valid;
    end

endmodule

// File: rtl/x_top_mem_arb.sv
// ---------------------------------------------------------------------------
// x_top_mem_arb
// Round-robin arbiter and sequencer between the core's instruction fetch
// (requester 0) and load/store port (requester 1) and the single memory port.
// One request is latched at a time and held on the downstream port until it
// is accepted or the watchdog expires; completion is reported with a single
// cycle o_accept pulse to the granted requester.
//
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_rnw/i_valid       : per-requester read-not-write and request valid
//   i_addr/i_data       : per-requester address and write data
//   o_accept            : per-requester completion pulse
//   o_data, o_err       : shared read data, timeout flag (valid with o_accept)
//   o_mem_*             : downstream request (rnw, valid, addr, write data)
//   i_mem_accept/i_mem_data : downstream accept and read data
// ---------------------------------------------------------------------------
module x_top_mem_arb
    import x_top_mem_arb_pkg::*;
#(
    parameter int          p_timeout  = 1000000,
    parameter logic [31:0] p_err_data = ERR_DATA_DEFAULT
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_rnw,
    input  logic [N_REQ-1:0]       i_valid,
    output logic [N_REQ-1:0]       o_accept,
    input  logic [N_REQ-1:0][31:0] i_addr,
    input  logic [N_REQ-1:0][31:0] i_data,
    output logic [31:0]            o_data,
    output logic                   o_err,
    output logic                   o_mem_rnw,
    output logic                   o_mem_valid,
    input  logic                   i_mem_accept,
    output logic [31:0]            o_mem_addr,
    output logic [31:0]            o_mem_data,
    input  logic [31:0]            i_mem_data
);

    // A disabled watchdog still needs a legal one-bit counter.
    localparam int WD_W = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(p_timeout - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    arb_state_t      r_state;
    req_idx_t        r_ptr;
    req_idx_t        r_grant;
    logic [WD_W-1:0] r_wd;

    req_idx_t        w_grant;
    logic            w_gnt_valid;

    x_top_rr_pick u_pick (
        .i_valid     (i_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_wd        <= '0;
            o_accept    <= '0;
            o_data      <= '0;
            o_err       <= 1'b0;
            o_mem_rnw   <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        o_mem_rnw   <= i_rnw[w_grant];
                        o_mem_addr  <= i_addr[w_grant];
                        o_mem_data  <= i_data[w_grant];
                        o_mem_valid <= 1'b1;
                        r_grant     <= w_grant;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    // Accept is tested first so it wins over a same-cycle timeout.
                    if (i_mem_accept) begin
                        o_mem_valid       <= 1'b0;
                        o_data            <= i_mem_data;
                        o_err             <= 1'b0;
                        o_accept[r_grant] <= 1'b1;
                        r_state           <= RESP;
                    end else if ((p_timeout != 0) && (r_wd == WD_LAST)) begin
                        o_mem_valid       <= 1'b0;
                        o_data            <= p_err_data;
                        o_err             <= 1'b1;
                        o_accept[r_grant] <= 1'b1;
                        r_state           <= RESP;
                    end else if (r_wd != WD_MAX) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                RESP: begin
                    // Hand priority to the requester that was not just served.
                    o_accept <= '0;
                    o_err    <= 1'b0;
                    r_ptr    <= ~r_grant;
                    r_wd     <= '0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_top_mem_arb.sv
module tb_x_top_mem_arb;

    localparam int          TMO     = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic             i_clk;
    logic             i_rst;
    logic [1:0]       i_rnw;
    logic [1:0]       i_valid;
    logic [1:0]       o_accept;
    logic [1:0][31:0] i_addr;
    logic [1:0][31:0] i_data;
    logic [31:0]      o_data;
    logic             o_err;
    logic             o_mem_rnw;
    logic             o_mem_valid;
    logic             i_mem_accept;
    logic [31:0]      o_mem_addr;
    logic [31:0]      o_mem_data;
    logic [31:0]      i_mem_data;

    x_top_mem_arb #(
        .p_timeout  (TMO),
        .p_err_data (ERR_VAL)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rnw        (i_rnw),
        .i_valid      (i_valid),
        .o_accept     (o_accept),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .o_data       (o_data),
        .o_err        (o_err),
        .o_mem_rnw    (o_mem_rnw),
        .o_mem_valid  (o_mem_valid),
        .i_mem_accept (i_mem_accept),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .i_mem_data   (i_mem_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Requester-side model state: what each requester is currently presenting.
    logic        v       [2];
    logic        req_rnw [2];
    logic [31:0] req_addr[2];
    logic [31:0] req_data[2];
    int          m_ptr;          // which requester the spec says has priority
    int          grant_log[$];   // order in which requesters were served

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            i_valid[n] = v[n];
            i_rnw[n]   = req_rnw[n];
            i_addr[n]  = req_addr[n];
            i_data[n]  = req_data[n];
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic rnw, input logic [31:0] addr,
                           input logic [31:0] data);
        v[n]        = 1'b1;
        req_rnw[n]  = rnw;
        req_addr[n] = addr;
        req_data[n] = data;
        drive();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        m_ptr = 0;
    endtask

    // Runs one complete transaction starting in an IDLE cycle with requests
    // already presented. delay = REQ cycles without accept before the accept
    // cycle; tmo = never accept. mutate/drop alter the granted requester's
    // inputs after the latch, which must have no effect.
    task automatic serve(input int delay, input bit tmo, input logic [31:0] rdata,
                         input bit mutate, input bit drop);
        int          g;
        int          waits;
        logic        rnw_l;
        logic [31:0] addr_l;
        logic [31:0] data_l;
        if (v[0] && v[1]) g = m_ptr;
        else              g = v[1] ? 1 : 0;
        rnw_l  = req_rnw[g];
        addr_l = req_addr[g];
        data_l = req_data[g];
        grant_log.push_back(g);

        step();
        chk("req_valid", 32'(o_mem_valid), 32'd1);
        chk("req_addr",  o_mem_addr, addr_l);
        chk("req_rnw",   32'(o_mem_rnw), 32'(rnw_l));
        if (!rnw_l) chk("req_wdata", o_mem_data, data_l);
        chk("req_noacc", 32'(o_accept), 32'd0);

        if (mutate) begin
            req_addr[g] = req_addr[g] + 32'd4;
            req_data[g] = ~req_data[g];
            req_rnw[g]  = ~req_rnw[g];
            drive();
        end
        if (drop) begin
            v[g] = 1'b0;
            drive();
        end

        waits = tmo ? (TMO - 1) : delay;
        for (int i = 0; i < waits; i++) begin
            step();
            chk("wait_valid", 32'(o_mem_valid), 32'd1);
            chk("wait_addr",  o_mem_addr, addr_l);
            chk("wait_noacc", 32'(o_accept), 32'd0);
        end

        if (!tmo) begin
            i_mem_accept = 1'b1;
            i_mem_data   = rdata;
        end
        step();
        i_mem_accept = 1'b0;
        i_mem_data   = $urandom;
        chk("resp_accept", 32'(o_accept), 32'(2'b01 << g));
        chk("resp_err",    32'(o_err), 32'(tmo));
        chk("resp_mvalid", 32'(o_mem_valid), 32'd0);
        if (tmo)        chk("resp_errdata", o_data, ERR_VAL);
        else if (rnw_l) chk("resp_rdata",   o_data, rdata);

        v[g] = 1'b0;
        drive();
        m_ptr = 1 - g;

        step();
        chk("idle_accept", 32'(o_accept), 32'd0);
        chk("idle_err",    32'(o_err), 32'd0);
        chk("idle_mvalid", 32'(o_mem_valid), 32'd0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_mem_accept = 1'b0;
        i_mem_data   = '0;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; req_rnw[n] = 1'b0; req_addr[n] = '0; req_data[n] = '0;
        end
        drive();
        m_ptr = 0;

        // Reset state
        step();
        chk("rst_accept", 32'(o_accept), 32'd0);
        chk("rst_data",   o_data, 32'd0);
        chk("rst_err",    32'(o_err), 32'd0);
        chk("rst_mvalid", 32'(o_mem_valid), 32'd0);
        chk("rst_maddr",  o_mem_addr, 32'd0);
        chk("rst_mrnw",   32'(o_mem_rnw), 32'd0);
        i_rst = 1'b0;
        step();

        // 1. Single read from requester 0
        set_req(0, 1'b1, 32'h0000_0010, 32'h0);
        serve(5, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

        // 2. Contention with pointer 0: req0 first, then req1 write
        do_reset();
        grant_log.delete();
        set_req(0, 1'b1, 32'h0000_0030, 32'h0);
        set_req(1, 1'b0, 32'h0000_0020, 32'hA5A5_A5A5);
        serve(2, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
        serve(1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("cont_first",  32'(grant_log[0]), 32'd0);
        chk("cont_second", 32'(grant_log[1]), 32'd1);

        // 3. Both held valid: grants must alternate 0,1,0,1
        grant_log.delete();
        for (int t = 0; t < 4; t++) begin
            if (!v[0]) set_req(0, 1'b1, 32'h100 + 32'(t), 32'h0);
            if (!v[1]) set_req(1, 1'b1, 32'h200 + 32'(t), 32'h0);
            serve(t, 1'b0, $urandom, 1'b0, 1'b0);
        end
        v[1] = 1'b0;
        drive();
        for (int t = 0; t < 4; t++) chk("alt_grant", 32'(grant_log[t]), 32'(t % 2));

        // 4. Timeout on requester 1 read
        set_req(1, 1'b1, 32'h0000_0050, 32'h0);
        serve(0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Accept in the last watchdog cycle wins over the timeout
        set_req(0, 1'b1, 32'h0000_0060, 32'h0);
        serve(TMO - 1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0);

        // 5. Reset mid-REQ drops o_mem_valid asynchronously, no accept
        set_req(0, 1'b1, 32'h0000_0070, 32'h0);
        step();
        chk("pre_rst_mvalid", 32'(o_mem_valid), 32'd1);
        step();
        i_rst = 1'b1;
        #1;
        chk("async_rst_mvalid", 32'(o_mem_valid), 32'd0);
        chk("async_rst_accept", 32'(o_accept), 32'd0);
        step();
        chk("in_rst_accept", 32'(o_accept), 32'd0);
        i_rst = 1'b0;
        m_ptr = 0;
        serve(3, 1'b0, 32'h7777_0070, 1'b0, 1'b0);

        // 6. Field change after latch is ignored
        set_req(0, 1'b1, 32'h0000_0040, 32'h0);
        serve(4, 1'b0, 32'h4040_4040, 1'b1, 1'b0);

        // Random traffic against the model
        for (int t = 0; t < 30; t++) begin
            int  dly;
            bit  tmo;
            for (int n = 0; n < 2; n++) begin
                if (!v[n] && ($urandom_range(1, 0) == 1))
                    set_req(n, 1'($urandom), $urandom, $urandom);
            end
            if (!v[0] && !v[1]) set_req(int'($urandom_range(1, 0)), 1'($urandom), $urandom, $urandom);
            tmo = ($urandom_range(7, 0) == 0);
            dly = int'($urandom_range(TMO - 1, 0));
            serve(dly, tmo, $urandom, 1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/x_top_mem_arb.md
Name: x_top_mem_arb

Overview:
Two-requester round-robin arbiter and sequencer in front of the single x_top_mem memory port.
- Requester 0 is the core instruction fetch; requester 1 is the core load/store port.
- Latches one request at a time, drives the downstream port until accept, then returns read data and accept to the granted requester.
- A watchdog terminates transactions the UART-backed memory never accepts.

Parameters:
p_timeout, 1000000, downstream wait cycles before abort; 0 disables the watchdog
p_err_data, 32'hDEAD_BEEF, read data returned on timeout

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_rnw  in  2  per-requester read-not-write; bit n = requester n
i_valid  in  2  per-requester request valid
o_accept  out  2  per-requester one-cycle completion pulse
i_addr  in  2x32  per-requester address, packed [1:0][31:0]
i_data  in  2x32  per-requester write data
o_data  out  32  read data, shared; valid when the o_accept bit is high
o_err  out  1  pulses with o_accept when the transaction timed out
o_mem_rnw  out  1  downstream read-not-write
o_mem_valid  out  1  downstream valid
i_mem_accept  in  1  downstream accept
o_mem_addr  out  32  downstream address
o_mem_data  out  32  downstream write data
i_mem_data  in  32  downstream read data, valid with i_mem_accept

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, state IDLE, priority pointer = 0, watchdog = 0.
  - Reset mid-transaction drops o_mem_valid immediately; no accept is issued to the pending requester.
- States:
  - IDLE:
    - No i_valid: stay.
    - Otherwise grant = the requesting index with priority; if only one requests, grant it.
    - Register rnw/addr/data of the grant into o_mem_*, store grant index, go to REQ.
  - REQ:
    - o_mem_valid = 1; o_mem_* stable.
    - On i_mem_accept: register i_mem_data into o_data, set o_accept[grant] = 1, go to RESP.
    - If p_timeout != 0 and watchdog == p_timeout-1 without accept: drop o_mem_valid, o_data = p_err_data, o_err = 1, o_accept[grant] = 1, go to RESP.
  - RESP:
    - One cycle; o_accept/o_err are high here only.
    - Priority pointer = ~grant; clear watchdog; go to IDLE.
- Latency:
  - Request sampled at edge N (IDLE) -> o_mem_valid high from N+1.
  - i_mem_accept at edge M -> o_accept high for cycle M+1.
  - Minimum turnaround: 3 cycles per transaction. Back-to-back requests are regranted in the IDLE cycle after RESP.
- Requester rules:
  - Holds i_valid and its fields until its o_accept pulse.
  - Deasserting i_valid after latching does not abort the transaction; accept still pulses.
  - Fields changing after latch are ignored.
- Fairness:
  - Simultaneous valid with pointer p grants p, then ~p.
  - Neither requester waits more than one transaction.
- Writes: o_data is undefined-but-registered on write accepts (forwards i_mem_data); the bench checks only o_accept.
- Watchdog width: $clog2(p_timeout+1) bits; saturates, no wrap.
- Accept and timeout in the same REQ cycle: accept wins, o_err = 0.
- Only one o_accept bit is ever high.

Decomposition:
- Package x_top_mem_arb_pkg:
  - state enum (IDLE, REQ, RESP)
  - requester count constant (2)
  - requester index typedef
  - default error-data constant
- Sub-module x_top_rr_pick: combinational 2-way round-robin selector (valid vector, pointer -> grant index, grant valid). Kept separate for reuse with more requesters later.

Test Plan:
1. Single read: req0 read addr 0x0000_0010; downstream accepts after 5 cycles with 0x1234_5678 -> o_mem_valid 1 cycle after request; o_accept=2'b01 one cycle after accept; o_data=0x1234_5678; o_err=0.
2. Contention: both valid at once, req1 write addr 0x20 data 0xA5A5_A5A5, pointer=0 -> req0 served first, then req1. o_mem_data=0xA5A5_A5A5 and o_mem_rnw=0 on the second grant; pointer ends at 0.
3. Starvation check: req0 held valid continuously with req1 valid -> grants alternate 0,1,0,1 over 4 transactions.
4. Timeout: p_timeout=16, req1 read, i_mem_accept never asserted -> o_mem_valid drops after 16 REQ cycles; o_accept=2'b10, o_err=1, o_data=0xDEAD_BEEF.
5. Reset mid-REQ: assert i_rst while o_mem_valid=1 -> o_mem_valid 0 without waiting for a clock edge; no o_accept pulse; after release, the held request is re-granted and completes normally.
6. Field change after latch: req0 addr changes 0x40->0x44 during REQ -> o_mem_addr stays 0x40 until completion.
